sfp_norm_row_dc: RTL and testbench

Parametrised next-generation special-function row for the attention core. It sits between the output FIFO and the psum memory. It consumes a programmable batch of psum rows and accumulates the sum of absolute values of all entries. In dual-core mode it exchanges that partial sum with the peer core over a symmetric valid handshake. It then emits each buffered row normalised by the total, one row per cycle, with backpressure.

---
 rtl/sfp_norm_row_dc.sv | 214 +++++++++++++++++++++
 tb/tb_sfp_norm_row_dc.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_norm_row_dc.sv
// Special-function row: accumulates |psum| over a batch, optionally merges the peer
// core's partial sum, then streams every buffered row normalised by the total.
module sfp_norm_row_dc #(
  parameter int unsigned col         = 8,
  parameter int unsigned bw_psum     = 20,
  parameter int unsigned bw_psum_out = 24,
  parameter int unsigned depth       = 8,
  parameter int unsigned frac        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [$clog2(depth):0] num_rows,
  input  logic                   dual,
  input  logic                   fifo_valid,
  input  logic [bw_psum*col-1:0] fifo_in,
  output logic                   fifo_rd,
  output logic [bw_psum_out-1:0] sum_out,
  output logic                   sum_out_valid,
  input  logic [bw_psum_out-1:0] sum_in,
  input  logic                   sum_in_valid,
  output logic [bw_psum*col-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CW   = $clog2(depth) + 1;
  localparam int unsigned AW   = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned RW   = bw_psum * col;
  localparam int unsigned AB   = bw_psum + 1;
  localparam int unsigned RAW  = AB + $clog2(col);
  localparam int unsigned SUMW = ((RAW > bw_psum_out) ? RAW : bw_psum_out) + 1;
  localparam int unsigned NW   = AB + frac;
  localparam int unsigned DW   = (NW > bw_psum_out) ? NW : bw_psum_out;

  localparam logic [bw_psum_out-1:0] MAXS = '1;
  localparam logic [DW-1:0]          MAXP = DW'((64'(1) << (bw_psum - 1)) - 64'(1));

  typedef enum logic [2:0] {IDLE, ACC, XCHG, DIV, FIN} state_t;

  state_t                 state;
  logic                   dual_q;
  logic [CW-1:0]          n;
  logic [CW-1:0]          row_cnt;
  logic [CW-1:0]          rd_cnt;
  logic [bw_psum_out-1:0] local_sum;
  logic [bw_psum_out-1:0] total;
  logic [RW-1:0]          buffer [depth];

  logic [CW-1:0]          n_c;
  logic                   pop_c;
  logic                   last_pop_c;
  logic                   accept_c;
  logic                   last_acc_c;
  logic [bw_psum_out-1:0] acc_sum_c;
  logic [bw_psum_out-1:0] xchg_total_c;
  logic [RW-1:0]          div_row_c;
  logic [bw_psum_out-1:0] div_tot_c;
  logic [RW-1:0]          norm_c;

  // |x| in one extra bit so the most negative psum is exact
  function automatic logic [AB-1:0] abs_lane(input logic [bw_psum-1:0] x);
    logic signed [AB-1:0] xe;
    xe = AB'($signed(x));
    return xe[AB-1] ? $unsigned(-xe) : $unsigned(xe);
  endfunction

  function automatic logic [SUMW-1:0] row_abs(input logic [RW-1:0] r);
    logic [SUMW-1:0] s;
    s = '0;
    for (int i = 0; i < int'(col); i++) s = s + SUMW'(abs_lane(r[i*bw_psum +: bw_psum]));
    return s;
  endfunction

  function automatic logic [bw_psum_out-1:0] sat_add(input logic [bw_psum_out-1:0] a,
                                                     input logic [SUMW-1:0]        b);
    logic [SUMW-1:0] s;
    s = SUMW'(a) + b;
    return (s > SUMW'(MAXS)) ? MAXS : s[bw_psum_out-1:0];
  endfunction

  function automatic logic [bw_psum-1:0] norm_lane(input logic [bw_psum-1:0]     x,
                                                   input logic [bw_psum_out-1:0] tot);
    logic [DW-1:0]      num;
    logic [DW-1:0]      q;
    logic [bw_psum-1:0] mag;
    num = DW'(abs_lane(x)) << frac;
    q   = (tot == '0) ? '0 : num / DW'(tot);
    if (q > MAXP) q = MAXP;
    mag = bw_psum'(q);
    return x[bw_psum-1] ? (~mag + bw_psum'(1)) : mag;
  endfunction

  function automatic logic [RW-1:0] norm_row(input logic [RW-1:0]          r,
                                             input logic [bw_psum_out-1:0] tot);
    logic [RW-1:0] o;
    o = '0;
    for (int i = 0; i < int'(col); i++) o[i*bw_psum +: bw_psum] = norm_lane(r[i*bw_psum +: bw_psum], tot);
    return o;
  endfunction

  assign n_c          = (num_rows > CW'(depth)) ? CW'(depth) : num_rows;
  assign pop_c        = (state == ACC) && fifo_valid;
  assign last_pop_c   = pop_c && (row_cnt == n - CW'(1));
  assign accept_c     = (state == DIV) && out_valid && out_ready;
  assign last_acc_c   = accept_c && (rd_cnt == n - CW'(1));
  assign acc_sum_c    = sat_add(local_sum, row_abs(fifo_in));
  assign xchg_total_c = sat_add(local_sum, SUMW'(sum_in));
  assign fifo_rd      = pop_c;
  assign busy         = (state != IDLE);

  // The first output row is computed on the way into DIV, bypassing the buffer and total
  always_comb begin
    div_row_c = buffer[AW'(rd_cnt + CW'(1))];
    div_tot_c = total;
    case (state)
      ACC: begin
        div_row_c = (n == CW'(1)) ? fifo_in : buffer[0];
        div_tot_c = acc_sum_c;
      end
      XCHG: begin
        div_row_c = buffer[0];
        div_tot_c = xchg_total_c;
      end
      default: ;
    endcase
    norm_c = norm_row(div_row_c, div_tot_c);
  end

  always_ff @(posedge clk) begin
    if (pop_c) buffer[row_cnt[AW-1:0]] <= fifo_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      dual_q        <= 1'b0;
      n             <= '0;
      row_cnt       <= '0;
      rd_cnt        <= '0;
      local_sum     <= '0;
      total         <= '0;
      sum_out       <= '0;
      sum_out_valid <= 1'b0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dual_q    <= dual;
            n         <= n_c;
            row_cnt   <= '0;
            local_sum <= '0;
            if (n_c == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (pop_c) begin
            row_cnt   <= row_cnt + CW'(1);
            local_sum <= acc_sum_c;
          end
          if (last_pop_c) begin
            if (dual_q) begin
              state         <= XCHG;
              sum_out       <= acc_sum_c;
              sum_out_valid <= 1'b1;
            end else begin
              state     <= DIV;
              total     <= acc_sum_c;
              rd_cnt    <= '0;
              out_data  <= norm_c;
              out_valid <= 1'b1;
            end
          end
        end
        XCHG: begin
          if (sum_in_valid) begin
            state         <= DIV;
            total         <= xchg_total_c;
            sum_out       <= '0;
            sum_out_valid <= 1'b0;
            rd_cnt        <= '0;
            out_data      <= norm_c;
            out_valid     <= 1'b1;
          end
        end
        DIV: begin
          if (last_acc_c) begin
            state     <= FIN;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b1;
          end else if (accept_c) begin
            rd_cnt   <= rd_cnt + CW'(1);
            out_data <= norm_c;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfp_norm_row_dc.sv
// Bench for sfp_norm_row_dc: hand-computed vector table, reset/abort sequence and
// randomized batches checked against an arithmetic reference model.
module tb_sfp_norm_row_dc;

  localparam int COL   = 8;
  localparam int BW    = 20;
  localparam int BWO   = 24;
  localparam int DEPTH = 8;
  localparam int FRAC  = 8;
  localparam int RW    = BW * COL;
  localparam longint SMAX = (64'(1) << BWO) - 1;
  localparam longint PMAX = (64'(1) << (BW - 1)) - 1;

  typedef logic [RW-1:0] row_t;

  typedef struct {
    int nr; bit dl; bit all; int v0; int v1; int peer; int pdelay; int rdy;
    int exp0; int exp1; longint lsum;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [3:0]     num_rows = '0;
  logic           dual = 1'b0;
  logic           fifo_valid = 1'b0;
  row_t           fifo_in = '0;
  logic           fifo_rd;
  logic [BWO-1:0] sum_out;
  logic           sum_out_valid;
  logic [BWO-1:0] sum_in = '0;
  logic           sum_in_valid = 1'b0;
  row_t           out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           busy;
  logic           done;

  int     total_cnt = 0;
  int     bad_cnt = 0;
  row_t   rows_in[$];
  row_t   src_q[$];
  row_t   exp_q[$];
  longint exp_local;
  longint peer_val;

  always #5 clk = ~clk;

  sfp_norm_row_dc #(.col(COL), .bw_psum(BW), .bw_psum_out(BWO), .depth(DEPTH), .frac(FRAC)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .dual(dual),
    .fifo_valid(fifo_valid), .fifo_in(fifo_in), .fifo_rd(fifo_rd),
    .sum_out(sum_out), .sum_out_valid(sum_out_valid), .sum_in(sum_in), .sum_in_valid(sum_in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    total_cnt++;
    if (act !== req) begin
      bad_cnt++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int lane_of(row_t r, int i);
    return int'($signed(r[i*BW +: BW]));
  endfunction

  function automatic row_t fill_row(int v, bit all);
    row_t r;
    r = '0;
    for (int i = 0; i < COL; i++) if (all || i == 0) r[i*BW +: BW] = BW'(v);
    return r;
  endfunction

  // Reference: saturating sum of |x| over the first n rows
  function automatic longint model_local(int n);
    longint s;
    s = 0;
    for (int r = 0; r < n; r++)
      for (int i = 0; i < COL; i++) begin
        int x;
        x = lane_of(rows_in[r], i);
        s += (x < 0) ? -longint'(x) : longint'(x);
        if (s > SMAX) s = SMAX;
      end
    return s;
  endfunction

  function automatic row_t model_norm(row_t r, longint tot);
    row_t o;
    o = '0;
    for (int i = 0; i < COL; i++) begin
      longint x, a, q, v;
      x = longint'(lane_of(r, i));
      a = (x < 0) ? -x : x;
      q = (tot == 0) ? 0 : (a * (64'(1) << FRAC)) / tot;
      if (q > PMAX) q = PMAX;
      v = (x < 0) ? -q : q;
      o[i*BW +: BW] = BW'(v);
    end
    return o;
  endfunction

  task automatic model_expect(input int nr, input bit dl);
    int n;
    longint tot;
    n = (nr > DEPTH) ? DEPTH : nr;
    exp_local = model_local(n);
    tot = dl ? exp_local + peer_val : exp_local;
    if (tot > SMAX) tot = SMAX;
    exp_q.delete();
    for (int r = 0; r < n; r++) exp_q.push_back(model_norm(rows_in[r], tot));
  endtask

  function automatic int rand_lane();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 600)) - 300;
      1: return int'($urandom_range(0, (1 << BW) - 1)) - (1 << (BW - 1));
      2: return ($urandom_range(0, 1) != 0) ? -(1 << (BW - 1)) : (1 << (BW - 1)) - 1;
      default: return 0;
    endcase
  endfunction

  // Drives one batch from rows_in; exp_q/exp_local must already hold the expectations
  task automatic run_batch(input int nr, input bit dl, input int pdelay, input int rdy_mode,
                           input int abort_acc);
    int n, pops, acc, ov_idx, sov_cnt, last_pop_cyc, first_ov_cyc, last_acc_cyc, cyc;
    bit last_pop_seen, xchg_done, done_seen, pop_now, exp_sov;
    int rdy_pat[5];
    rdy_pat = '{1, 0, 0, 1, 1};
    n = (nr > DEPTH) ? DEPTH : nr;
    pops = 0; acc = 0; ov_idx = 0; sov_cnt = 0;
    last_pop_cyc = -1; first_ov_cyc = -1; last_acc_cyc = -1;
    last_pop_seen = 0; xchg_done = 0; done_seen = 0;
    src_q = rows_in;
    @(negedge clk);
    start = 1'b1; num_rows = 4'(nr); dual = dl;
    for (cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      @(negedge clk);
      start      = (cyc == 1);
      num_rows   = 4'($urandom);
      dual       = 1'($urandom);
      fifo_valid = (src_q.size() > 0) && ($urandom_range(0, 3) != 0);
      fifo_in    = (src_q.size() > 0) ? src_q[0] : row_t'(0);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom);
        default: out_ready = 1'(rdy_pat[ov_idx % 5]);
      endcase
      if (dl) begin
        sum_in       = BWO'(peer_val);
        sum_in_valid = !xchg_done && (pdelay < 0 || (last_pop_seen && sov_cnt >= pdelay));
      end else begin
        sum_in       = BWO'($urandom);
        sum_in_valid = 1'($urandom);
      end
      #1;
      exp_sov = dl && last_pop_seen && !xchg_done;
      chk("sum_out_valid", sum_out_valid, exp_sov);
      chk("sum_out", sum_out, exp_sov ? exp_local : 0);
      if (exp_sov) begin
        sov_cnt++;
        if (sum_in_valid) xchg_done = 1;
      end
      pop_now = fifo_rd;
      if (fifo_rd && !fifo_valid) chk("fifo_rd without valid", 1, 0);
      if (pop_now) begin
        pops++;
        if (pops == n) begin last_pop_seen = 1; last_pop_cyc = cyc; end
      end
      if (out_valid) begin
        ov_idx++;
        if (first_ov_cyc < 0) first_ov_cyc = cyc;
        if (exp_q.size() == 0) chk("spurious out_valid", 1, 0);
        else begin
          chk("out_data", out_data, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            acc++;
            last_acc_cyc = cyc;
          end
        end
      end
      if (done) begin
        done_seen = 1;
        chk("done timing", cyc, (n == 0) ? 0 : last_acc_cyc + 1);
        chk("rows left", exp_q.size(), 0);
        chk("pop count", pops, n);
      end
      if (abort_acc > 0 && acc == abort_acc) break;
      @(posedge clk);
      if (pop_now) void'(src_q.pop_front());
    end
    start = 1'b0;
    if (abort_acc > 0) return;
    if (!done_seen) chk("done timeout", 0, 1);
    if (!dl && n > 0) chk("first out latency", first_ov_cyc - last_pop_cyc, 1);
    @(negedge clk);
    #1;
    chk("busy after done", busy, 0);
    chk("done single pulse", done, 0);
    fifo_valid = 1'b0;
    sum_in_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_data"}, out_data, 0);
    chk({tag, " sum_out_valid"}, sum_out_valid, 0);
    chk({tag, " sum_out"}, sum_out, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " fifo_rd"}, fifo_rd, 0);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{2,  0, 1, 4,       -4,      0,     0,  0, 16,  -16, 64};
    tbl[1] = '{1,  1, 0, 100,     0,       156,   5,  0, 100, 0,   100};
    tbl[2] = '{8,  0, 1, -524288, -524288, 0,     0,  0, -8,  -8,  SMAX};
    tbl[3] = '{3,  0, 1, 4,       -4,      0,     0,  2, 10,  -10, 96};
    tbl[4] = '{15, 0, 1, 1,       -1,      0,     0,  0, 4,   -4,  64};
    tbl[5] = '{0,  0, 1, 5,       5,       0,     0,  0, 0,   0,   0};
    tbl[6] = '{1,  0, 1, 0,       0,       0,     0,  1, 0,   0,   0};
    tbl[7] = '{2,  1, 1, 1000,    -1000,   16000, -1, 1, 8,   -8,  16000};

    repeat (3) @(negedge clk);
    fifo_valid = 1'b1;
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    fifo_valid = 1'b0;

    for (int t = 0; t < 8; t++) begin
      int n;
      n = (tbl[t].nr > DEPTH) ? DEPTH : tbl[t].nr;
      rows_in.delete();
      exp_q.delete();
      for (int r = 0; r < tbl[t].nr; r++)
        rows_in.push_back(fill_row((r % 2 == 0) ? tbl[t].v0 : tbl[t].v1, tbl[t].all));
      for (int r = 0; r < n; r++)
        exp_q.push_back(fill_row((r % 2 == 0) ? tbl[t].exp0 : tbl[t].exp1, tbl[t].all));
      exp_local = tbl[t].lsum;
      peer_val  = tbl[t].peer;
      run_batch(tbl[t].nr, tbl[t].dl, tbl[t].pdelay, tbl[t].rdy, 0);
    end

    // Abort in DIV after the first accepted row, then a clean batch
    rows_in.delete();
    for (int r = 0; r < 3; r++) rows_in.push_back(fill_row((r == 1) ? -4000 : 4000, 1));
    peer_val = 0;
    model_expect(3, 0);
    run_batch(3, 0, 0, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("abort");
    @(negedge clk);
    reset = 1'b1;
    fifo_valid = 1'b0;
    rows_in.delete();
    rows_in.push_back(fill_row(4, 1));
    rows_in.push_back(fill_row(-4, 1));
    model_expect(2, 0);
    chk("model sum after abort", exp_local, 64);
    run_batch(2, 0, 0, 0, 0);

    for (int k = 0; k < 25; k++) begin
      int nr;
      bit dl;
      nr = int'($urandom_range(0, 15));
      dl = 1'($urandom);
      rows_in.delete();
      for (int r = 0; r < nr; r++) begin
        row_t rr;
        rr = '0;
        for (int i = 0; i < COL; i++) rr[i*BW +: BW] = BW'(rand_lane());
        rows_in.push_back(rr);
      end
      peer_val = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, int'(SMAX)))
                                            : longint'($urandom_range(0, 5000));
      model_expect(nr, dl);
      run_batch(nr, dl, int'($urandom_range(0, 7)) - 1, 1, 0);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
